cpu_run_ctrl: RTL and testbench
===============================

// Module: cpu_run_ctrl
// PURPOSE
//  Sequences execution of the single-cycle CPU core from the board buttons: halt, free-run,
//  single-step, and a hardware PC breakpoint. Sits between the buttons/switches and the CPU.
//  Its cpu_ce output drives the CPU clock enable; the top level gates the CPU clock with cpu_ce.
//  Each cycle with cpu_ce=1 retires exactly one instruction.
// PARAMETERS
//  DB_CYCLES   1000000  consecutive stable cycles required before a button level is accepted
//  DB_W        20       debounce counter width; must satisfy 2**DB_W > DB_CYCLES
// PORTS
//  clk        in   1   system clock; all state updates on its rising edge
//  rstn       in   1   asynchronous, active-low reset
//  btn_run    in   1   raw run/halt button, asynchronous; each press toggles run/halt
//  btn_step   in   1   raw single-step button, asynchronous
//  brk_en     in   1   breakpoint enable (switch), level
//  brk_addr   in   32  breakpoint PC
//  pc         in   32  current CPU pc (address of the instruction to execute next)
//  cpu_ce     out  1   CPU clock enable; combinational from state and breakpoint match
//  state      out  2   00 HALT, 01 RUN, 10 STEP, 11 BRK
//  brk_hit    out  1   sticky flag: the most recent stop was caused by the breakpoint
//  inst_cnt   out  32  count of cycles with cpu_ce=1 (instructions retired)
// BEHAVIOUR
//  Reset (rstn=0, asynchronous): state=HALT, cpu_ce=0, brk_hit=0, inst_cnt=0.
//   Synchronisers, debounced levels, debounce counters and skip are all cleared.
//   Reset may assert in any state; the block is in HALT the cycle after rstn rises.
//  Input conditioning, per button:
//   - 2-FF synchroniser.
//   - Debounce counter: cleared whenever the synced level equals the debounced level;
//     otherwise increments. At DB_CYCLES-1 the debounced level takes the synced level
//     and the counter clears.
//   - Pulse: run_p/step_p is high for 1 cycle on each debounced rising edge.
//   - Latency from a clean press to the pulse: 2 + DB_CYCLES cycles.
//  Breakpoint match: brk_m = brk_en & (pc == brk_addr) & ~skip.
//  FSM (next state registered; where both pulses arrive together, step_p has priority):
//   HALT: step_p->STEP; run_p->RUN, and skip<=1; else stay.
//   RUN:  step_p or run_p->HALT (cpu_ce=0 that cycle);
//         brk_m->BRK, brk_hit<=1, cpu_ce=0, so the instruction at brk_addr does NOT execute;
//         else stay.
//   STEP: always ->HALT after one cycle. skip<=0. Buttons are ignored while in STEP.
//   BRK:  step_p->STEP; run_p->RUN with skip<=1; brk_hit<=0 on either pulse.
//  skip:
//   - Set on entry to RUN. Cleared on the first RUN cycle with cpu_ce=1, and on entry to STEP.
//   - This lets resume-from-breakpoint execute the breakpointed instruction once.
//  cpu_ce = (state==STEP) | (state==RUN & ~brk_m & ~run_p & ~step_p).
//   STEP executes regardless of the breakpoint.
//  inst_cnt: +1 on every clock edge where cpu_ce=1; wraps 0xFFFFFFFF->0 silently.
//  brk_hit: also cleared by a pulse in HALT.
//  brk_addr/brk_en changes take effect on the same cycle (combinational compare).
// TESTING (DB_CYCLES=4)
//  Reset, then hold btn_step high 10 cycles: exactly 1 cycle of cpu_ce=1;
//   state goes HALT->STEP->HALT; inst_cnt=1.
//  Glitch btn_run high 2 cycles then low: no pulse; state stays HALT; cpu_ce stays 0.
//  Press run, pc model increments by 4 per ce, brk_en=1, brk_addr=0x20:
//   cpu_ce falls the cycle pc==0x20; state=BRK; brk_hit=1; inst_cnt=8.
//  From BRK press run: cpu_ce=1 with pc=0x20 (skip); run continues;
//   brk_hit=0; a loop back to 0x20 re-triggers BRK.
//  Run and step pulses in the same HALT cycle: state->STEP; one instruction; then HALT.
//  Assert rstn=0 mid-RUN asynchronously: cpu_ce=0 immediately;
//   state=HALT and inst_cnt=0 before the next clk edge.

Source files
------------

// File: rtl/cpu_run_ctrl_if.sv
// ---------------------------------------------------------------------------
// cpu_run_ctrl_if: button/breakpoint inputs and CPU control outputs of cpu_run_ctrl
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface cpu_run_ctrl_if;
   logic        btn_run;
   logic        btn_step;
   logic        brk_en;
   logic [31:0] brk_addr;
   logic [31:0] pc;
   logic        cpu_ce;
   logic [1:0]  state;
   logic        brk_hit;
   logic [31:0] inst_cnt;

   modport master (
      output btn_run, btn_step, brk_en, brk_addr, pc,
      input  cpu_ce, state, brk_hit, inst_cnt
   );

   modport slave (
      input  btn_run, btn_step, brk_en, brk_addr, pc,
      output cpu_ce, state, brk_hit, inst_cnt
   );
endinterface

`default_nettype wire

// File: rtl/cpu_run_ctrl.sv
// ---------------------------------------------------------------------------
// cpu_run_ctrl: halt / free-run / single-step / PC-breakpoint sequencer for the CPU clock enable
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module cpu_run_ctrl #(
   parameter int DB_CYCLES = 1000000,
   parameter int DB_W      = 20
) (
   input  logic          clk,
   input  logic          rstn,
   cpu_run_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      S_HALT = 2'b00,
      S_RUN  = 2'b01,
      S_STEP = 2'b10,
      S_BRK  = 2'b11
   } state_t;

   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

   logic [1:0] btn_raw;
   logic [1:0] pulse;
   logic       run_p;
   logic       step_p;

   assign btn_raw = {bus.btn_step, bus.btn_run};

   for (genvar i = 0; i < 2; i++) begin : g_btn
      logic            sync1_q;
      logic            sync2_q;
      logic            db_q;
      logic            pulse_q;
      logic [DB_W-1:0] cnt_q;

      always_ff @(posedge clk or negedge rstn) begin
         if (!rstn) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            db_q    <= 1'b0;
            pulse_q <= 1'b0;
            cnt_q   <= '0;
         end else begin
            sync1_q <= btn_raw[i];
            sync2_q <= sync1_q;
            pulse_q <= 1'b0;
            if (sync2_q == db_q) begin
               cnt_q <= '0;
            end else if (cnt_q == DB_LAST) begin
               // Pulse is registered alongside the level change, so it marks rising edges only
               db_q    <= sync2_q;
               pulse_q <= sync2_q;
               cnt_q   <= '0;
            end else begin
               cnt_q <= cnt_q + 1'b1;
            end
         end
      end

      assign pulse[i] = pulse_q;
   end

   assign run_p  = pulse[0];
   assign step_p = pulse[1];

   state_t      state_q, state_d;
   logic        skip_q, skip_d;
   logic        brk_hit_q, brk_hit_d;
   logic [31:0] inst_cnt_q;
   logic        brk_m;
   logic        cpu_ce;

   assign brk_m  = bus.brk_en & (bus.pc == bus.brk_addr) & ~skip_q;
   assign cpu_ce = (state_q == S_STEP) |
                   ((state_q == S_RUN) & ~brk_m & ~run_p & ~step_p);

   always_comb begin
      state_d   = state_q;
      skip_d    = skip_q;
      brk_hit_d = brk_hit_q;
      unique case (state_q)
         S_HALT, S_BRK: begin
            if (step_p) begin
               state_d   = S_STEP;
               skip_d    = 1'b0;
               brk_hit_d = 1'b0;
            end else if (run_p) begin
               // skip lets a resume execute the breakpointed instruction once
               state_d   = S_RUN;
               skip_d    = 1'b1;
               brk_hit_d = 1'b0;
            end
         end
         S_RUN: begin
            if (cpu_ce) begin
               skip_d = 1'b0;
            end
            if (step_p || run_p) begin
               state_d = S_HALT;
            end else if (brk_m) begin
               state_d   = S_BRK;
               brk_hit_d = 1'b1;
            end
         end
         S_STEP: begin
            state_d = S_HALT;
            skip_d  = 1'b0;
         end
         default: state_d = S_HALT;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q    <= S_HALT;
         skip_q     <= 1'b0;
         brk_hit_q  <= 1'b0;
         inst_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         skip_q    <= skip_d;
         brk_hit_q <= brk_hit_d;
         if (cpu_ce) begin
            inst_cnt_q <= inst_cnt_q + 32'd1;
         end
      end
   end

   assign bus.cpu_ce   = cpu_ce;
   assign bus.state    = state_q;
   assign bus.brk_hit  = brk_hit_q;
   assign bus.inst_cnt = inst_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_cpu_run_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cpu_run_ctrl: directed + randomized bench for cpu_run_ctrl against a behavioural model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_cpu_run_ctrl;
   localparam int DB     = 4;
   localparam int M_HALT = 0;
   localparam int M_RUN  = 1;
   localparam int M_STEP = 2;
   localparam int M_BRK  = 3;

   logic clk = 1'b0;
   logic rstn;

   cpu_run_ctrl_if bus ();

   cpu_run_ctrl #(
      .DB_CYCLES (DB),
      .DB_W      (3)
   ) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Behavioural model state
   int          m_mode;
   bit          m_skip;
   bit          m_hit;
   logic [31:0] m_inst;
   logic [31:0] m_pc;
   bit          m_rp;
   bit          m_sp;
   bit          m_ret;
   bit          m_db   [2];
   bit          hist   [2][DB+1];

   int          ce_seen;
   int          step_seen;
   bit          first_pending;
   logic [31:0] first_pc;
   logic        first_hit;

   function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endfunction

   function automatic void model_reset();
      m_mode = M_HALT;
      m_skip = 1'b0;
      m_hit  = 1'b0;
      m_inst = '0;
      m_rp   = 1'b0;
      m_sp   = 1'b0;
      m_ret  = 1'b0;
      for (int b = 0; b < 2; b++) begin
         m_db[b] = 1'b0;
         for (int j = 0; j <= DB; j++) hist[b][j] = 1'b0;
      end
   endfunction

   function automatic bit model_brk();
      return bus.brk_en && (bus.pc == bus.brk_addr) && !m_skip;
   endfunction

   function automatic bit model_ce();
      return (m_mode == M_STEP) ||
             (m_mode == M_RUN && !model_brk() && !m_rp && !m_sp);
   endfunction

   // One rising clock edge of the specified behaviour
   function automatic void model_edge();
      bit ce, brk, all_diff;
      bit raw [2];
      bit p   [2];
      ce  = model_ce();
      brk = model_brk();
      m_ret = ce;
      if (ce) m_inst = m_inst + 32'd1;
      case (m_mode)
         M_HALT, M_BRK: begin
            if (m_sp) begin
               m_mode = M_STEP; m_skip = 1'b0; m_hit = 1'b0;
            end else if (m_rp) begin
               m_mode = M_RUN;  m_skip = 1'b1; m_hit = 1'b0;
            end
         end
         M_RUN: begin
            if (ce) m_skip = 1'b0;
            if (m_sp || m_rp) m_mode = M_HALT;
            else if (brk) begin
               m_mode = M_BRK; m_hit = 1'b1;
            end
         end
         default: begin
            m_mode = M_HALT; m_skip = 1'b0;
         end
      endcase
      // Debounced level flips once the last DB synchronised samples all disagree with it
      raw[0] = bus.btn_run;
      raw[1] = bus.btn_step;
      for (int b = 0; b < 2; b++) begin
         all_diff = 1'b1;
         for (int j = 0; j < DB; j++) if (hist[b][j] == m_db[b]) all_diff = 1'b0;
         p[b] = 1'b0;
         if (all_diff) begin
            m_db[b] = !m_db[b];
            p[b]    = m_db[b];
         end
         for (int j = 0; j < DB; j++) hist[b][j] = hist[b][j+1];
         hist[b][DB] = raw[b];
      end
      m_rp = p[0];
      m_sp = p[1];
   endfunction

   task automatic compare_all();
      chk("cpu_ce",   32'(bus.cpu_ce),  32'(model_ce()));
      chk("state",    32'(bus.state),   32'(m_mode));
      chk("brk_hit",  32'(bus.brk_hit), 32'(m_hit));
      chk("inst_cnt", bus.inst_cnt,     m_inst);
      if (bus.cpu_ce === 1'b1) begin
         ce_seen++;
         if (first_pending) begin
            first_pending = 1'b0;
            first_pc      = bus.pc;
            first_hit     = bus.brk_hit;
         end
      end
      if (bus.state === 2'b10) step_seen++;
   endtask

   // Called at a falling edge; drives buttons, compares, then advances one clock
   task automatic tick(input bit br, input bit bs);
      bus.btn_run  = br;
      bus.btn_step = bs;
      bus.pc       = m_pc;
      #1;
      compare_all();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      if (m_ret) m_pc = (m_pc + 32'd4) & 32'h3F;
      bus.pc = m_pc;
   endtask

   task automatic press(input bit br, input bit bs, input int hold, input int gap);
      repeat (hold) tick(br, bs);
      repeat (gap) tick(1'b0, 1'b0);
   endtask

   task automatic sync_reset();
      rstn         = 1'b0;
      bus.btn_run  = 1'b0;
      bus.btn_step = 1'b0;
      m_pc         = '0;
      bus.pc       = '0;
      model_reset();
      repeat (2) @(negedge clk);
      rstn = 1'b1;
   endtask

   task automatic async_reset();
      bus.btn_run  = 1'b0;
      bus.btn_step = 1'b0;
      #3;
      rstn = 1'b0;
      #1;
      chk("arst_cpu_ce",   32'(bus.cpu_ce),  32'd0);
      chk("arst_state",    32'(bus.state),   32'd0);
      chk("arst_inst_cnt", bus.inst_cnt,     32'd0);
      chk("arst_brk_hit",  32'(bus.brk_hit), 32'd0);
      model_reset();
      m_pc   = '0;
      bus.pc = '0;
      repeat (2) @(negedge clk);
      rstn = 1'b1;
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      rstn         = 1'b0;
      bus.btn_run  = 1'b0;
      bus.btn_step = 1'b0;
      bus.brk_en   = 1'b0;
      bus.brk_addr = '0;
      bus.pc       = '0;
      m_pc         = '0;
      first_pending = 1'b0;
      first_pc     = '0;
      first_hit    = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      #1;
      chk("rst_state",    32'(bus.state),   32'd0);
      chk("rst_cpu_ce",   32'(bus.cpu_ce),  32'd0);
      chk("rst_inst_cnt", bus.inst_cnt,     32'd0);
      chk("rst_brk_hit",  32'(bus.brk_hit), 32'd0);
      @(negedge clk);
      rstn = 1'b1;

      // Held step button: one instruction, through STEP back to HALT
      ce_seen = 0; step_seen = 0;
      press(1'b0, 1'b1, 10, 8);
      chk("step_ce_cycles", 32'(ce_seen),   32'd1);
      chk("step_seen",      32'(step_seen), 32'd1);
      chk("step_inst_cnt",  bus.inst_cnt,   32'd1);
      chk("step_state",     32'(bus.state), 32'd0);

      // Short glitch on run must not be accepted
      ce_seen = 0;
      press(1'b1, 1'b0, 2, 12);
      chk("glitch_ce_cycles", 32'(ce_seen),   32'd0);
      chk("glitch_state",     32'(bus.state), 32'd0);

      // Free run into a breakpoint at 0x20
      sync_reset();
      bus.brk_en   = 1'b1;
      bus.brk_addr = 32'h20;
      press(1'b1, 1'b0, 6, 0);
      for (int i = 0; i < 40 && bus.state !== 2'b11; i++) tick(1'b0, 1'b0);
      #1;
      chk("brk_state",    32'(bus.state),   32'd3);
      chk("brk_hit_set",  32'(bus.brk_hit), 32'd1);
      chk("brk_inst_cnt", bus.inst_cnt,     32'd8);
      chk("brk_cpu_ce",   32'(bus.cpu_ce),  32'd0);
      chk("brk_pc",       m_pc,             32'h20);

      // Resume executes 0x20 once, then the loop re-triggers the breakpoint
      first_pending = 1'b1;
      press(1'b1, 1'b0, 8, 0);
      for (int i = 0; i < 60 && bus.state !== 2'b11; i++) tick(1'b0, 1'b0);
      #1;
      chk("resume_first_pc",  first_pc,              32'h20);
      chk("resume_hit_clear", 32'(first_hit),        32'd0);
      chk("rebrk_state",      32'(bus.state),        32'd3);
      chk("rebrk_inst_cnt",   bus.inst_cnt,          32'd24);
      chk("rebrk_brk_hit",    32'(bus.brk_hit),      32'd1);
      tick(1'b0, 1'b0);

      // Step out of BRK, then run+step together in HALT: step wins
      press(1'b0, 1'b1, 8, 8);
      chk("brkstep_inst_cnt", bus.inst_cnt,     32'd25);
      chk("brkstep_brk_hit",  32'(bus.brk_hit), 32'd0);
      ce_seen = 0; step_seen = 0;
      press(1'b1, 1'b1, 8, 8);
      chk("both_ce_cycles", 32'(ce_seen),   32'd1);
      chk("both_step_seen", 32'(step_seen), 32'd1);
      chk("both_inst_cnt",  bus.inst_cnt,   32'd26);
      chk("both_state",     32'(bus.state), 32'd0);

      // Asynchronous reset in the middle of a run
      bus.brk_en = 1'b0;
      press(1'b1, 1'b0, 8, 3);
      chk("mid_run_state", 32'(bus.state), 32'd1);
      async_reset();
      tick(1'b0, 1'b0);

      // Randomized phase
      for (int it = 0; it < 220; it++) begin
         int a;
         a = int'($urandom_range(0, 19));
         if (a < 5)
            press(1'b1, 1'b0, int'($urandom_range(1, 9)), int'($urandom_range(0, 10)));
         else if (a < 9)
            press(1'b0, 1'b1, int'($urandom_range(1, 9)), int'($urandom_range(0, 10)));
         else if (a < 10)
            press(1'b1, 1'b1, int'($urandom_range(1, 9)), int'($urandom_range(0, 10)));
         else if (a < 13) begin
            bus.brk_en   = 1'($urandom_range(0, 1));
            bus.brk_addr = 32'($urandom_range(0, 15)) << 2;
            tick(1'b0, 1'b0);
         end else if (a < 14)
            async_reset();
         else
            repeat (int'($urandom_range(1, 25))) tick(1'b0, 1'b0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
